// File: rtl/challenge_responder_if.sv
// Challenge responder bus: request channel, hash-engine channel and response channel.
// master = requester/hash-engine side, slave = challenge_responder.
interface challenge_responder_if #(
    parameter int unsigned MSG_LEN   = 256,
    parameter int unsigned NUM_SLOTS = 8,
    parameter int unsigned DIGEST_W  = 192
);
    logic                  req_valid;
    logic                  req_ready;
    logic [MSG_LEN-1:0]    req_msg;
    logic [7:0]            req_slot;
    logic [NUM_SLOTS-1:0]  slot_mask;

    logic                  hash_start;
    logic [MSG_LEN-25:0]   hash_nonce;
    logic [7:0]            hash_slot;
    logic                  hash_done;
    logic [DIGEST_W-1:0]   hash_digest;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_header;
    logic [MSG_LEN-33:0]   resp_payload;
    logic [1:0]            resp_err;

    modport master (
        output req_valid, req_msg, req_slot, slot_mask, hash_done, hash_digest, resp_ready,
        input  req_ready, hash_start, hash_nonce, hash_slot, resp_valid, resp_header,
               resp_payload, resp_err
    );

    modport slave (
        input  req_valid, req_msg, req_slot, slot_mask, hash_done, hash_digest, resp_ready,
        output req_ready, hash_start, hash_nonce, hash_slot, resp_valid, resp_header,
               resp_payload, resp_err
    );
endinterface

// File: rtl/challenge_responder.sv
// CHALLENGE request handler: validates nonce/slot, drives an external hash engine and builds
// the CHALLENGE_AUTH response. Define CHALLENGE_TIMEOUT_EN to add the hash-wait timeout.
`ifndef PROTOCOL_VERSION
`define PROTOCOL_VERSION 8'h12
`endif
`ifndef CHALLENGE_AUTH_CMD
`define CHALLENGE_AUTH_CMD 8'h03
`endif
`ifndef CAPABILITIES
`define CAPABILITIES 8'h5A
`endif

module challenge_responder #(
    parameter int unsigned MSG_LEN        = 256,
    parameter int unsigned NUM_SLOTS      = 8,
    parameter int unsigned DIGEST_W       = 192,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_L,
    challenge_responder_if.slave bus
);
    localparam int unsigned NonceW  = MSG_LEN - 24;
    localparam int unsigned PayW    = MSG_LEN - 32;
    localparam int unsigned DigPadW = MSG_LEN - 64;

    typedef enum logic [2:0] {StIdle, StCheck, StHash, StWait, StResp} state_e;

    state_e               state_q;
    logic [NonceW-1:0]    nonce_q;
    logic [7:0]           slot_q;
    logic [NUM_SLOTS-1:0] mask_q;
    logic                 hash_start_q;
    logic                 resp_valid_q;
    logic [1:0]           err_q;
    logic [31:0]          header_q;
    logic [PayW-1:0]      payload_q;

    logic [7:0] mask_ext;
    logic       slot_ok;

    assign mask_ext = 8'(mask_q);
    assign slot_ok  = (32'(slot_q) < NUM_SLOTS) && mask_ext[slot_q[2:0]];

`ifdef CHALLENGE_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    logic [CntW-1:0] tmo_cnt_q;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    // Low header bytes of the request carry nothing this block consumes.
    logic unused_msg;
    assign unused_msg = ^bus.req_msg[23:0];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= StIdle;
            nonce_q      <= '0;
            slot_q       <= '0;
            mask_q       <= '0;
            hash_start_q <= 1'b0;
            resp_valid_q <= 1'b0;
            err_q        <= 2'd0;
            header_q     <= '0;
            payload_q    <= '0;
`ifdef CHALLENGE_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            hash_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        nonce_q <= bus.req_msg[MSG_LEN-1:24];
                        slot_q  <= bus.req_slot;
                        mask_q  <= bus.slot_mask;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (nonce_q == '0) begin
                        err_q        <= 2'd1;
                        header_q     <= '0;
                        payload_q    <= '0;
                        resp_valid_q <= 1'b1;
                        state_q      <= StResp;
                    end else if (!slot_ok) begin
                        err_q        <= 2'd2;
                        header_q     <= '0;
                        payload_q    <= '0;
                        resp_valid_q <= 1'b1;
                        state_q      <= StResp;
                    end else begin
                        hash_start_q <= 1'b1;
                        state_q      <= StHash;
                    end
                end
                StHash: begin
`ifdef CHALLENGE_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                    state_q   <= StWait;
                end
                StWait: begin
                    // hash_done takes priority over an expiring timeout in the same cycle.
                    if (bus.hash_done) begin
                        err_q        <= 2'd0;
                        header_q     <= {`PROTOCOL_VERSION, `CHALLENGE_AUTH_CMD, slot_q, mask_ext};
                        payload_q    <= {`PROTOCOL_VERSION, `PROTOCOL_VERSION, `CAPABILITIES,
                                         8'h00, DigPadW'(bus.hash_digest)};
                        resp_valid_q <= 1'b1;
                        state_q      <= StResp;
                    end
`ifdef CHALLENGE_TIMEOUT_EN
                    else if (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        err_q        <= 2'd3;
                        header_q     <= '0;
                        payload_q    <= '0;
                        resp_valid_q <= 1'b1;
                        state_q      <= StResp;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end
                StResp: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready    = (state_q == StIdle);
    assign bus.hash_start   = hash_start_q;
    assign bus.hash_nonce   = nonce_q;
    assign bus.hash_slot    = slot_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_err     = err_q;
    assign bus.resp_header  = header_q;
    assign bus.resp_payload = payload_q;
endmodule

// File: tb/tb_challenge_responder.sv
// Self-checking bench for challenge_responder: directed protocol cases plus randomized
// transactions checked against a rule-level outcome model.
module tb_challenge_responder;
    localparam int unsigned MSG_LEN   = 256;
    localparam int unsigned NUM_SLOTS = 8;
    localparam int unsigned DIGEST_W  = 160;
    localparam int          TMO       = 16;
    localparam int unsigned NW        = MSG_LEN - 24;
    localparam int unsigned PW        = MSG_LEN - 32;
    localparam int unsigned PAD       = MSG_LEN - 64 - DIGEST_W;
    localparam logic [7:0]  PV        = 8'h12;
    localparam logic [7:0]  CMD       = 8'h03;
    localparam logic [7:0]  CAP       = 8'h5A;
    localparam int          BUDGET    = 200;
`ifdef CHALLENGE_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    int   checks = 0;
    int   failures = 0;

    challenge_responder_if #(
        .MSG_LEN  (MSG_LEN),
        .NUM_SLOTS(NUM_SLOTS),
        .DIGEST_W (DIGEST_W)
    ) bus ();

    challenge_responder #(
        .MSG_LEN       (MSG_LEN),
        .NUM_SLOTS     (NUM_SLOTS),
        .DIGEST_W      (DIGEST_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk    (clk),
        .reset_L(reset_L),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [MSG_LEN-1:0] rand_bits();
        logic [MSG_LEN-1:0] v;
        for (int i = 0; i < int'(MSG_LEN / 32); i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Outcome from the protocol rules; d < 0 means hash_done never arrives. lat counts cycles
    // from accept until resp_valid is visible.
    function automatic void predict(input logic [NW-1:0] nonce, input logic [7:0] slot,
                                    input logic [7:0] mask, input int d,
                                    input logic [DIGEST_W-1:0] dig, output int err,
                                    output int lat, output int n_hs, output logic [31:0] hdr,
                                    output logic [PW-1:0] pay);
        hdr  = '0;
        pay  = '0;
        n_hs = 1;
        if (nonce == '0) begin
            err = 1; lat = 2; n_hs = 0;
        end else if (slot >= NUM_SLOTS || mask[slot[2:0]] == 1'b0) begin
            err = 2; lat = 2; n_hs = 0;
        end else if (TmoEn && (d < 0 || d > TMO)) begin
            err = 3; lat = 3 + TMO;
        end else begin
            err = 0; lat = 3 + d;
            hdr = {PV, CMD, slot, mask};
            pay = {PV, PV, CAP, 8'h00, {PAD{1'b0}}, dig};
        end
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset_L = 1'b0;
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic run_txn(input logic [NW-1:0] nonce, input logic [7:0] slot,
                           input logic [7:0] mask, input int d, input int rdly,
                           input bit spurious, input string tag);
        logic [MSG_LEN-1:0]  rb;
        logic [DIGEST_W-1:0] dig;
        logic [31:0]         hdr;
        logic [PW-1:0]       pay;
        int err, lat, n_hs, c, hs_cnt, hs_cyc, resp_cyc;
        rb  = rand_bits();
        dig = rb[MSG_LEN-1 -: DIGEST_W];
        predict(nonce, slot, mask, d, dig, err, lat, n_hs, hdr, pay);

        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_msg     = {nonce, rb[23:0]};
        bus.req_slot    = slot;
        bus.slot_mask   = mask;
        bus.hash_digest = dig;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s req_ready_idle: got %b want 1", tag, bus.req_ready);
        end
        @(posedge clk);
        #1;
        // Scramble request inputs to prove they were captured at accept.
        bus.req_valid = 1'b0;
        bus.req_slot  = 8'($urandom());
        bus.slot_mask = 8'($urandom());
        bus.req_msg   = rand_bits();

        c = 0; hs_cnt = 0; hs_cyc = -1; resp_cyc = -1;
        while (resp_cyc < 0 && c < BUDGET) begin
            @(negedge clk);
            c++;
            if (bus.hash_start === 1'b1) begin
                hs_cnt++;
                hs_cyc = c;
                checks++;
                if (bus.hash_nonce !== nonce || bus.hash_slot !== slot) begin
                    failures++;
                    $display("FAIL %s hash_latch: got nonce=%h slot=%0d want nonce=%h slot=%0d",
                             tag, bus.hash_nonce, bus.hash_slot, nonce, slot);
                end
            end
            if (bus.resp_valid === 1'b1) resp_cyc = c;
            bus.hash_done = (resp_cyc < 0) &&
                            ((spurious && c == 1) || (hs_cyc > 0 && d > 0 && c == hs_cyc + d));
        end
        bus.hash_done = 1'b0;

        checks++;
        if (hs_cnt != n_hs) begin
            failures++;
            $display("FAIL %s hash_start_count: got %0d want %0d", tag, hs_cnt, n_hs);
        end
        checks++;
        if (resp_cyc != lat) begin
            failures++;
            $display("FAIL %s resp_latency: got %0d want %0d", tag, resp_cyc, lat);
        end
        checks++;
        if (bus.resp_err !== 2'(err) || bus.resp_header !== hdr || bus.resp_payload !== pay) begin
            failures++;
            $display("FAIL %s resp_fields: got err=%0d hdr=%h pay=%h want err=%0d hdr=%h pay=%h",
                     tag, bus.resp_err, bus.resp_header, bus.resp_payload, err, hdr, pay);
        end
        if (n_hs == 1) begin
            checks++;
            if (bus.hash_nonce !== nonce || bus.hash_slot !== slot) begin
                failures++;
                $display("FAIL %s hash_hold: got nonce=%h slot=%0d want nonce=%h slot=%0d",
                         tag, bus.hash_nonce, bus.hash_slot, nonce, slot);
            end
        end

        // Back-pressure: response must hold, and a stray hash_done must be ignored.
        for (int i = 0; i < rdly; i++) begin
            bus.hash_done   = spurious && i == 0;
            bus.hash_digest = ~dig;
            @(negedge clk);
            bus.hash_done = 1'b0;
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.resp_err !== 2'(err) ||
                bus.resp_header !== hdr || bus.resp_payload !== pay) begin
                failures++;
                $display("FAIL %s resp_hold[%0d]: got valid=%b ready=%b err=%0d hdr=%h want 1 0 %0d %h",
                         tag, i, bus.resp_valid, bus.req_ready, bus.resp_err, bus.resp_header,
                         err, hdr);
            end
        end

        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s handshake_done: got valid=%b ready=%b want 0 1", tag,
                     bus.resp_valid, bus.req_ready);
        end
        if (resp_cyc < 0) apply_reset();
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s req_ready: got %b want 1", tag, bus.req_ready);
        end
        checks++;
        if ({bus.hash_start, bus.resp_valid, bus.resp_err, bus.resp_header, bus.resp_payload,
             bus.hash_nonce, bus.hash_slot} !== '0) begin
            failures++;
            $display("FAIL %s outputs_zero: got hs=%b rv=%b err=%0d hdr=%h nonce=%h slot=%0d want 0",
                     tag, bus.hash_start, bus.resp_valid, bus.resp_err, bus.resp_header,
                     bus.hash_nonce, bus.hash_slot);
        end
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_L = 1'b1;
    endtask

    task automatic test_ok();
        logic [NW-1:0] n;
        n = {29{8'hA5}};
        run_txn(n, 8'd2, 8'h04, 3, 2, 1'b0, "ok_a5");
    endtask

    task automatic test_errors();
        logic [NW-1:0] n;
        n = {29{8'h3C}};
        run_txn('0, 8'd2, 8'h04, 3, 1, 1'b1, "err_nonce0");
        run_txn(n, 8'd9, 8'hFF, 3, 0, 1'b0, "err_slot9");
        run_txn(n, 8'd1, 8'h04, 3, 0, 1'b1, "err_mask");
        run_txn('0, 8'd9, 8'h00, 3, 0, 1'b0, "err_priority");
    endtask

    task automatic test_backpressure();
        run_txn(NW'(rand_bits()) | NW'(1), 8'd7, 8'h80, 5, 10, 1'b1, "stall10");
    endtask

    task automatic test_timeout();
        logic [NW-1:0] n;
        n = NW'(rand_bits()) | NW'(1);
        run_txn(n, 8'd0, 8'h01, TMO, 0, 1'b0, "done_at_limit");
        run_txn(n, 8'd0, 8'h01, TMO + 1, 0, 1'b0, "done_late");
        if (TmoEn) run_txn(n, 8'd0, 8'h01, -1, 1, 1'b0, "never_done");
        else run_txn(n, 8'd0, 8'h01, 40, 1, 1'b0, "long_wait");
    endtask

    task automatic test_reset_in_wait();
        int c;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_msg   = rand_bits() | MSG_LEN'(32'h0100_0000);
        bus.req_slot  = 8'd3;
        bus.slot_mask = 8'h08;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        c = 0;
        while (bus.hash_start !== 1'b1 && c < BUDGET) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (bus.hash_start !== 1'b1) begin
            failures++;
            $display("FAIL rst_wait hash_start_seen: got %b want 1", bus.hash_start);
        end
        repeat (2) @(negedge clk);
        reset_L = 1'b0;
        #1;
        check_reset_outputs("rst_wait");
        @(negedge clk);
        reset_L = 1'b1;
        run_txn(NW'(rand_bits()) | NW'(1), 8'd5, 8'h20, 2, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [NW-1:0] n;
        logic [7:0]    s;
        logic [7:0]    m;
        for (int i = 0; i < 40; i++) begin
            n = ($urandom_range(0, 7) == 0) ? '0 : NW'(rand_bits());
            s = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) :
                8'($urandom_range(0, 7));
            m = 8'($urandom());
            if ($urandom_range(0, 1) == 1) m[s[2:0]] = 1'b1;
            run_txn(n, s, m, int'($urandom_range(1, 20)), int'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_msg     = '0;
        bus.req_slot    = '0;
        bus.slot_mask   = '0;
        bus.hash_done   = 1'b0;
        bus.hash_digest = '0;
        bus.resp_ready  = 1'b0;
        test_reset();
        test_ok();
        test_errors();
        test_backpressure();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/challenge_responder.md
CHALLENGE_RESPONDER -- requirements
Module: challenge_responder

Interface
REQ-001 SHALL have parameter MSG_LEN, default 256, total message width in bits (header 32 + payload).
REQ-002 SHALL have parameter NUM_SLOTS, default 8, number of certificate slots (1..8).
REQ-003 SHALL have parameter DIGEST_W, default 192, hash digest width; legal range is DIGEST_W <= MSG_LEN-64.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, hash wait limit in clocks (>=2).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_L, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port req_valid, input, 1 bit: a CHALLENGE request is present.
REQ-008 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-009 SHALL have port req_msg, input, MSG_LEN bits: request message; nonce = req_msg[MSG_LEN-1:24].
REQ-010 SHALL have port req_slot, input, 8 bits: requested slot (Param1).
REQ-011 SHALL have port slot_mask, input, NUM_SLOTS bits: provisioned slots; sampled at accept.
REQ-012 SHALL have port hash_start, output, 1 bit: one-cycle pulse to the external hash engine.
REQ-013 SHALL have port hash_nonce, output, MSG_LEN-24 bits: latched nonce.
REQ-014 SHALL have port hash_slot, output, 8 bits: latched slot.
REQ-015 SHALL have port hash_done, input, 1 bit: digest is valid this cycle.
REQ-016 SHALL have port hash_digest, input, DIGEST_W bits: digest from the hash engine.
REQ-017 SHALL have port resp_valid, output, 1 bit: a response is presented.
REQ-018 SHALL have port resp_ready, input, 1 bit: the consumer accepts the response.
REQ-019 SHALL have port resp_header, output, 32 bits: response header.
REQ-020 SHALL have port resp_payload, output, MSG_LEN-32 bits: response payload.
REQ-021 SHALL have port resp_err, output, 2 bits: 0 = ok, 1 = invalid request, 2 = unsupported slot, 3 = timeout.

Function
REQ-022 SHALL implement the FSM states IDLE, CHECK, HASH, WAIT and RESP; req_ready=1 only in IDLE.
REQ-023 SHALL accept a request when req_valid&&req_ready in IDLE, latch the nonce, req_slot and slot_mask, and move to CHECK.
REQ-024 SHALL, in CHECK, use this priority: zero nonce -> err 1; else req_slot>=NUM_SLOTS or slot_mask[req_slot]==0 -> err 2; else -> HASH.
REQ-025 SHALL, on an error, enter RESP with resp_err set and resp_header=0, resp_payload=0; an error response therefore asserts resp_valid two cycles after accept.
REQ-026 SHALL, in HASH, assert hash_start for exactly one cycle and then move to WAIT.
REQ-027 SHALL, in WAIT, on hash_done register resp_header={`PROTOCOL_VERSION,`CHALLENGE_AUTH_CMD,slot,slot_mask zero-extended to 8}, register resp_payload={`PROTOCOL_VERSION,`PROTOCOL_VERSION,`CAPABILITIES,8'h00,hash_digest zero-extended left}, set resp_err=0, and go to RESP.
REQ-028 SHALL, in RESP, hold resp_valid and all response fields stable until resp_ready; on resp_valid&&resp_ready go to IDLE and clear resp_valid.
REQ-029 SHALL take no action on hash_done outside WAIT.
REQ-030 SHALL hold hash_nonce and hash_slot stable from HASH until the next accept.

Reset
REQ-031 SHALL, while reset_L=0 (including mid-transaction), force the FSM to IDLE, clear the timeout counter, drive req_ready=1, and drive hash_start, resp_valid, resp_err, resp_header, resp_payload, hash_nonce and hash_slot to 0.
REQ-032 SHALL resume normal operation on the first rising clk edge after reset_L rises.

Configuration
REQ-033 SHALL, with CHALLENGE_TIMEOUT_EN defined, count clocks in WAIT; when the count reaches TIMEOUT_CYCLES without hash_done, it SHALL enter RESP with err 3; hash_done in the expiry cycle SHALL win and give ok.
REQ-034 SHALL, with CHALLENGE_TIMEOUT_EN undefined, contain no counter and wait in WAIT indefinitely; err 3 is then never produced.

Verification
REQ-035 SHALL cover: nonce 0xA5.., slot 2, slot_mask 8'h04, hash_done 3 cycles after hash_start -> one hash_start pulse, resp_err 0, resp_header[15:8]=2, resp_header[7:0]=8'h04, payload low bits=digest.
REQ-036 SHALL cover: nonce 0 -> resp_valid two cycles after accept, resp_err 1, no hash_start.
REQ-037 SHALL cover: slot 9 (NUM_SLOTS=8), and slot 1 with slot_mask 8'h04 -> resp_err 2 in both cases.
REQ-038 SHALL cover: macro defined, TIMEOUT_CYCLES=16, hash_done never -> resp_err 3 after 16 WAIT cycles; hash_done in cycle 16 -> resp_err 0.
REQ-039 SHALL cover: resp_ready held low 10 cycles -> response stable and req_ready=0 throughout; reset_L pulsed low in WAIT -> all outputs 0 and req_ready=1 immediately.
